// File: rtl/arb_pkg.sv
// Shared types and defaults for the four-way round-robin arbiter.
// The log2 helper lets instances confirm that the index width matches the requester count.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N = 4;
  localparam int ARB_W = 2;

  function automatic int arb_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: the first set request at or after ptr wins.
// The request vector is rotated so ptr lands on bit 0, resolved LSB-first, then rotated back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int W = ARB_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] pick_idx,
  output logic         any
);

  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_req_shr;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_pick;
  logic [2*N-1:0] w_pick_dbl;
  logic [2*N-1:0] w_pick_shl;
  logic [W-1:0]   w_rot_idx;

  assign w_req_dbl  = {req, req};
  assign w_req_shr  = w_req_dbl >> ptr;
  assign w_rot      = w_req_shr[N-1:0];

  // Two's-complement trick isolates the lowest set bit of the rotated vector.
  assign w_rot_pick = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});

  assign w_pick_dbl = {w_rot_pick, w_rot_pick};
  assign w_pick_shl = w_pick_dbl << ptr;
  assign pick       = w_pick_shl[2*N-1:N];

  always_comb begin
    w_rot_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (w_rot_pick[k]) w_rot_idx = W'(k);
    end
  end

  assign pick_idx = w_rot_idx + ptr;
  assign any      = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter: registered one-hot grant held until the owner pulses done.
// Outputs come straight from flops so the downstream encoder sees a clean one-hot vector.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int W = ARB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  if (W != arb_log2(N)) begin : g_width_check
    $error("rr_arbiter_4: W must equal log2(N)");
  end

  arb_state_t   r_state;
  arb_state_t   w_state_nxt;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;
  logic [N-1:0] r_gnt;
  logic [N-1:0] w_gnt_nxt;
  logic [W-1:0] r_gnt_idx;
  logic [W-1:0] w_gnt_idx_nxt;
  logic         r_gnt_valid;
  logic         w_gnt_valid_nxt;

  logic [N-1:0] w_pick;
  logic [W-1:0] w_pick_idx;
  logic         w_any;

  rr_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt       = w_pick;
          w_gnt_idx_nxt   = w_pick_idx;
          w_gnt_valid_nxt = 1'b1;
          w_state_nxt     = GRANT;
        end
      end
      GRANT: begin
        // Only done releases; req changes while granted are deliberately ignored.
        if (done) begin
          w_gnt_nxt       = '0;
          w_gnt_idx_nxt   = '0;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_gnt_idx + W'(1);
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed vector table plus a few multi-cycle sequences and a modelled random run.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_pass;
  int n_tot;

  rr_arbiter_4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] ix, input logic v);
    vec_t e;
    e.rst = r; e.req = rq; e.done = d; e.gnt = g; e.idx = ix; e.vld = v;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 4-to-2 encoder, as the downstream block would implement it.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Behavioural model state for the random run.
  logic       m_busy;
  logic [1:0] m_ptr;
  logic [3:0] m_gnt;
  logic [1:0] m_idx;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
    logic [1:0] j;
    logic       found;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_gnt = 0; m_idx = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int s = 0; s < 4; s++) begin
        j = m_ptr + 2'(s);
        if (!found && rq[j]) begin
          found = 1; m_idx = j; m_gnt = 4'b0001 << j; m_busy = 1;
        end
      end
    end else if (d) begin
      m_ptr = m_idx + 2'd1; m_busy = 0; m_gnt = 0; m_idx = 0;
    end
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1; req = 0; done = 0;

    //  rst  req      done  gnt      idx  vld
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1);
    add(0, 4'b0001, 1, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1);
    add(0, 4'b1010, 0, 4'b0100, 2, 1);
    add(0, 4'b0000, 0, 4'b0100, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b0011, 0, 4'b0001, 0, 1);
    add(0, 4'b0011, 1, 4'b0000, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1);
    add(1, 4'b0110, 0, 4'b0000, 0, 0);
    add(0, 4'b0110, 0, 4'b0010, 1, 1);
    add(0, 4'b0110, 1, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1);
    add(1, 4'b0100, 1, 4'b0000, 0, 0);
    add(0, 4'b1001, 0, 4'b0001, 0, 1);
    add(0, 4'b1001, 1, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; done = vecs[i].done;
      tick();
      chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d.idx", i), 32'(gnt_idx), 32'(vecs[i].idx));
      chk($sformatf("vec%0d.vld", i), 32'(gnt_valid), 32'(vecs[i].vld));
    end

    // done held high continuously: grant every other cycle, rotating through all four.
    rst = 1; req = 0; done = 0;
    tick();
    rst = 0; req = 4'b1111; done = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c % 2 == 0) begin
        chk($sformatf("stream%0d.gnt", c), 32'(gnt), 32'(4'b0001 << ((c / 2) % 4)));
        chk($sformatf("stream%0d.idx", c), 32'(gnt_idx), 32'((c / 2) % 4));
      end else begin
        chk($sformatf("stream%0d.vld", c), 32'(gnt_valid), 32'd0);
      end
    end

    // Short request pulse while granted is never seen; only held requests win.
    rst = 1; req = 0; done = 0;
    tick();
    rst = 0; req = 4'b0001;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000; done = 1;
    tick();
    done = 0;
    tick();
    chk("pulse_lost.vld", 32'(gnt_valid), 32'd0);

    // Random run against the behavioural model and the downstream encoder.
    rst = 1; req = 0; done = 0;
    model_step(1, 0, 0);
    tick();
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 2) == 0);
      model_step(rst, req, done);
      tick();
      chk($sformatf("rnd%0d.gnt", c), 32'(gnt), 32'(m_gnt));
      chk($sformatf("rnd%0d.idx", c), 32'(gnt_idx), 32'(m_idx));
      chk($sformatf("rnd%0d.vld", c), 32'(gnt_valid), 32'(m_busy));
      if (gnt_valid)
        chk($sformatf("rnd%0d.enc", c), 32'(enc4(gnt)), 32'(gnt_idx));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Round-robin request arbiter for four requesters. It samples a 4-bit request vector and issues a registered one-hot grant that is held until the owner signals `done`. It also outputs the 2-bit binary index of the winner. The block sits directly upstream of the 4-to-2 encoder: `gnt` is a guaranteed one-hot (or all-zero) vector that the encoder consumes, and `gnt_idx` is the cross-check value the encoder must reproduce.

## Interface
- `N`, default 4: number of requesters; power of two, ≥2.
- `W`, default 2: index width, equal to log2(N).

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  request vector; bit k set means requester k wants the resource.
- `done`  in  1  single-cycle pulse from the current grant holder releasing the resource.
- `gnt`  out  N  registered one-hot grant; all-zero when no grant is active.
- `gnt_idx`  out  W  binary index of the set bit in `gnt`; 0 when `gnt` is zero.
- `gnt_valid`  out  1  high exactly while `gnt` is non-zero.

## Operation
- Internal state:
  - FSM state: IDLE or GRANT.
  - Priority pointer `ptr`, W bits: the requester with highest priority for the next arbitration.
- IDLE:
  - If `req` is non-zero, select the first set bit scanning `ptr`, `ptr+1`, … mod N.
  - Load `gnt`, `gnt_idx` and `gnt_valid=1`, then enter GRANT.
  - If `req` is zero, outputs stay zero and the FSM stays in IDLE.
- GRANT:
  - `gnt`, `gnt_idx` and `gnt_valid` hold constant regardless of `req`.
  - Dropping the holder's request does not release the grant; only `done` does.
  - On `done=1`: clear all outputs, set `ptr <= gnt_idx + 1` (mod N, natural wrap of W bits), enter IDLE.
- `done` in IDLE is ignored.
- Invariants:
  - `gnt` has at most one bit set.
  - `gnt == (1 << gnt_idx)` whenever `gnt_valid=1`.
- Reset values: `gnt=0`, `gnt_idx=0`, `gnt_valid=0`, `ptr=0`, state IDLE.
- `rst` has priority over every other input, including in GRANT. Reset mid-grant drops the grant at that edge.

## Timing
- Request to grant: 1 cycle. A request seen in IDLE at edge t produces `gnt_valid=1` after edge t.
- Release: `done` sampled high at edge t produces `gnt=0` after edge t.
- Re-arbitration: the earliest new grant appears after edge t+1. There is exactly one dead cycle between consecutive grants, even with pending requests.
- Throughput: at most one grant per 2 cycles when each holder pulses `done` in its first granted cycle.
- A request that appears and vanishes between edges while the FSM is in GRANT is never seen. Requesters must hold `req` until granted.
- Simultaneous `rst` and `done`: reset wins, and `ptr` returns to 0.
- All outputs are driven directly from flops; there is no combinational path from `req` or `done` to any output.

## Structure
- Package `arb_pkg` holds:
  - the state enum {IDLE, GRANT};
  - default `N`/`W` localparams;
  - a function returning log2 of N, for width checks.
- Sub-module `rr_pick` is the purely combinational rotating-priority selector.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `pick`, binary `pick_idx`, `any`.
  - Implemented as rotate-right by `ptr`, fixed LSB-first priority, then rotate-left back.
- The top level contains only the FSM, `ptr`, and the output registers.

## Test plan
- Basic grant: reset, then `req=0001` → one cycle later `gnt=0001`, `gnt_idx=00`, `gnt_valid=1`. Pulse `done` → next cycle `gnt=0000`, `gnt_valid=0`.
- Fairness: `req=1111` held; pulse `done` in each grant's first cycle → grant sequence 0001, 0010, 0100, 1000, 0001 with `gnt_idx` 0, 1, 2, 3, 0, and one idle cycle between each.
- Pointer wrap: after granting requester 3 (`ptr=0`)… and separately after granting requester 2 (`ptr=3`), apply `req=0011` → `gnt=0001`, confirming wrap from 3 to 0.
- Hold and ignore: during GRANT of 0100, change `req` to 1010 and to 0000 → `gnt` stays 0100. Pulse `done` while in IDLE with `req=0` → all outputs stay 0.
- Reset mid-grant: assert `rst` while `gnt=0010` → next cycle all outputs 0 and `ptr=0`. Release `rst` with `req=0110` → `gnt=0010`, `gnt_idx=01`.
- Downstream consistency: for every cycle of a random `req`/`done` run, feed `gnt` into the 4-to-2 encoder and check encoder output == `gnt_idx` whenever `gnt_valid=1`.
